axi4_wr_burst_arbiter: RTL and testbench



---
 rtl/axi4_wr_burst_arbiter_if.sv | 44 ++++
 rtl/axi4_wr_burst_arbiter.sv | 135 +++++++++++++
 tb/tb_axi4_wr_burst_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_wr_burst_arbiter_if.sv
// AXI4 write-channel bundle (AW, W, B) between the burst arbiter and one slave port.
// The read channels are not part of this bundle.
interface axi4_wr_burst_arbiter_if #(
    parameter int unsigned IdWidth   = 1,
    parameter int unsigned AddrWidth = 13,
    parameter int unsigned DataWidth = 32
);
    logic [IdWidth-1:0]     awid;
    logic [AddrWidth-1:0]   awaddr;
    logic [7:0]             awlen;
    logic [2:0]             awsize;
    logic [1:0]             awburst;
    logic                   awvalid;
    logic                   awready;

    logic [DataWidth-1:0]   wdata;
    logic [DataWidth/8-1:0] wstrb;
    logic                   wlast;
    logic                   wvalid;
    logic                   wready;

    logic [IdWidth-1:0]     bid;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi4_wr_burst_arbiter.sv
// Two-requester round-robin AXI4 write-burst master: one INCR burst per grant,
// sequenced AW -> W -> B, with bursts crossing a 4 KiB page rejected locally.
module axi4_wr_burst_arbiter #(
    parameter int unsigned C_M00_AXI_ID_WIDTH   = 1,
    parameter int unsigned C_M00_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_M00_AXI_ADDR_WIDTH = 13
) (
    input  logic                                m00_axi_aclk,
    input  logic                                m00_axi_areset,
    input  logic [1:0]                          req_valid,
    input  logic [2*C_M00_AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [15:0]                         req_len,
    output logic [1:0]                          req_ready,
    input  logic [2*C_M00_AXI_DATA_WIDTH-1:0]   req_wdata,
    input  logic [1:0]                          req_wvalid,
    output logic [1:0]                          req_wready,
    output logic [1:0]                          req_done,
    output logic [1:0]                          req_err,
    axi4_wr_burst_arbiter_if.master             m00_axi
);
    localparam int unsigned AddrW = C_M00_AXI_ADDR_WIDTH;
    localparam int unsigned DataW = C_M00_AXI_DATA_WIDTH;

    typedef enum logic [2:0] {StIdle, StAw, StW, StB, StErr} state_e;

    state_e           state_q, state_d;
    logic             grant_q, grant_d;
    logic             rr_q, rr_d;      // requester that wins the next tie
    logic [AddrW-1:0] addr_q, addr_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       beat_q, beat_d;

    logic             gnt_sel;
    logic [AddrW-1:0] sel_addr;
    logic [7:0]       sel_len;
    logic [12:0]      page_end;
    logic             crosses;
    logic             w_hs;

    assign gnt_sel  = (&req_valid) ? rr_q : req_valid[1];
    assign sel_addr = gnt_sel ? req_addr[2*AddrW-1:AddrW] : req_addr[AddrW-1:0];
    assign sel_len  = gnt_sel ? req_len[15:8] : req_len[7:0];

    // One past the last byte of the burst, measured from the start of its 4 KiB page.
    assign page_end = {1'b0, sel_addr[11:2], 2'b00} + {3'b000, sel_len, 2'b00} + 13'd4;
    assign crosses  = page_end > 13'd4096;

    assign w_hs = m00_axi.wvalid & m00_axi.wready;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_d     = beat_q;
        req_ready  = '0;
        req_wready = '0;
        req_done   = '0;
        req_err    = '0;
        unique case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    grant_d            = gnt_sel;
                    req_ready[gnt_sel] = 1'b1;
                    addr_d             = {sel_addr[AddrW-1:2], 2'b00};
                    len_d              = sel_len;
                    state_d            = crosses ? StErr : StAw;
                end
            end
            StAw: begin
                if (m00_axi.awready) begin
                    beat_d  = '0;
                    state_d = StW;
                end
            end
            StW: begin
                req_wready[grant_q] = m00_axi.wready;
                if (w_hs) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_q == len_q) begin
                        state_d = StB;
                    end
                end
            end
            StB: begin
                if (m00_axi.bvalid) begin
                    req_done[grant_q] = 1'b1;
                    req_err[grant_q]  = |m00_axi.bresp;
                    rr_d              = ~grant_q;
                    state_d           = StIdle;
                end
            end
            StErr: begin
                req_done[grant_q] = 1'b1;
                req_err[grant_q]  = 1'b1;
                rr_d              = ~grant_q;
                state_d           = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
        if (m00_axi_areset) begin
            state_q <= StIdle;
            grant_q <= 1'b0;
            rr_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
        end
    end

    assign m00_axi.awid    = C_M00_AXI_ID_WIDTH'(grant_q);
    assign m00_axi.awaddr  = addr_q;
    assign m00_axi.awlen   = len_q;
    assign m00_axi.awsize  = 3'b010;
    assign m00_axi.awburst = 2'b01;
    assign m00_axi.awvalid = (state_q == StAw);

    assign m00_axi.wdata  = grant_q ? req_wdata[2*DataW-1:DataW] : req_wdata[DataW-1:0];
    assign m00_axi.wstrb  = '1;
    assign m00_axi.wvalid = (state_q == StW) & req_wvalid[grant_q];
    assign m00_axi.wlast  = (state_q == StW) & (beat_q == len_q);

    assign m00_axi.bready = (state_q == StB);
endmodule

// File: tb/tb_axi4_wr_burst_arbiter.sv
// Randomized bench for axi4_wr_burst_arbiter: a transaction-level scoreboard predicts grants,
// AW fields, beat data/wlast and completion status from the arbitration and page rules.
module tb_axi4_wr_burst_arbiter;
    localparam int unsigned AW = 13;

    typedef enum int {TxNone, TxAddr, TxData, TxResp, TxReject} tx_e;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      req_valid = '0;
    logic [2*AW-1:0] req_addr = '0;
    logic [15:0]     req_len = '0;
    logic [1:0]      req_ready;
    logic [63:0]     req_wdata = '0;
    logic [1:0]      req_wvalid = '0;
    logic [1:0]      req_wready;
    logic [1:0]      req_done;
    logic [1:0]      req_err;

    axi4_wr_burst_arbiter_if #(.IdWidth(1), .AddrWidth(AW), .DataWidth(32)) axi ();

    axi4_wr_burst_arbiter #(
        .C_M00_AXI_ID_WIDTH  (1),
        .C_M00_AXI_DATA_WIDTH(32),
        .C_M00_AXI_ADDR_WIDTH(AW)
    ) dut (
        .m00_axi_aclk  (clk),
        .m00_axi_areset(rst),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_len       (req_len),
        .req_ready     (req_ready),
        .req_wdata     (req_wdata),
        .req_wvalid    (req_wvalid),
        .req_wready    (req_wready),
        .req_done      (req_done),
        .req_err       (req_err),
        .m00_axi       (axi.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Offered requests
    logic [1:0]    pend = '0;
    logic [AW-1:0] p_addr [2];
    logic [7:0]    p_len  [2];

    // Outstanding transaction
    tx_e           ph = TxNone;
    int            g = 0;
    logic [AW-1:0] c_addr;
    int            c_len;
    int            beats;
    int            last_served = 1;
    int            tx_seq [2];
    int            rx_seq [2];

    // Results of the most recent completion
    int last_beats, last_err, last_g;
    int grant_log [$];

    // Slave/requester behaviour knobs
    int         p_aw = 100, p_w = 100, p_b = 100, p_wv = 100;
    int         aw_hold = 0, aw_wait = 0;
    bit         w_toggle = 0, tog = 0;
    bit         use_force = 1;
    logic [1:0] force_bresp = 2'b00;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit chance(input int p);
        return $urandom_range(99, 0) < p;
    endfunction

    function automatic logic [31:0] word(input int i, input int n);
        logic [31:0] iv;
        logic [31:0] nv;
        iv = i;
        nv = n;
        return {iv[3:0], nv[27:0]} ^ 32'hA5C3_0000;
    endfunction

    function automatic logic [1:0] onehot(input int i);
        return (i == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic post(input int i, input logic [AW-1:0] a, input logic [7:0] l);
        pend[i]   = 1'b1;
        p_addr[i] = a;
        p_len[i]  = l;
    endtask

    task automatic complete(input int err);
        last_served = g;
        last_beats  = beats;
        last_err    = err;
        last_g      = g;
    endtask

    task automatic cycle();
        tx_e        cur;
        logic [1:0] exp_done;
        logic [1:0] exp_err;
        int         eg;
        int         start;
        @(negedge clk);
        req_valid = pend;
        req_addr  = {p_addr[1], p_addr[0]};
        req_len   = {p_len[1], p_len[0]};
        for (int i = 0; i < 2; i++) begin
            req_wvalid[i]          = chance(p_wv);
            req_wdata[i*32 +: 32]  = word(i, tx_seq[i]);
        end
        if (ph == TxAddr) axi.awready = (aw_wait >= aw_hold) && chance(p_aw);
        else              axi.awready = chance(50);
        axi.wready = w_toggle ? tog : chance(p_w);
        tog        = ~tog;
        axi.bid    = 1'($urandom_range(1, 0));
        axi.bvalid = (ph == TxResp) && chance(p_b);
        if (axi.bvalid) axi.bresp = use_force ? force_bresp
                                              : (chance(25) ? 2'($urandom_range(3, 1)) : 2'b00);
        else            axi.bresp = 2'($urandom_range(3, 0));
        #1;
        cur      = ph;
        exp_done = '0;
        exp_err  = '0;
        for (int i = 0; i < 2; i++) if (req_wvalid[i] && req_wready[i]) tx_seq[i]++;
        case (cur)
            TxAddr: begin
                check_eq("awvalid", axi.awvalid, 1);
                check_eq("awaddr", axi.awaddr, {c_addr[AW-1:2], 2'b00});
                check_eq("awlen", axi.awlen, c_len);
                check_eq("awid", axi.awid, g);
                check_eq("wvalid_pre_aw", axi.wvalid, 0);
                aw_wait++;
                if (axi.awready) begin
                    ph    = TxData;
                    beats = 0;
                end
            end
            TxData: begin
                check_eq("awvalid_in_w", axi.awvalid, 0);
                check_eq("wvalid_pass", axi.wvalid, req_wvalid[g]);
                check_eq("wready_pass", req_wready, axi.wready ? onehot(g) : 2'b00);
                if (axi.wvalid && axi.wready) begin
                    check_eq("wdata", axi.wdata, word(g, rx_seq[g]));
                    check_eq("wlast", axi.wlast, beats == c_len);
                    rx_seq[g]++;
                    beats++;
                    if (beats == c_len + 1) ph = TxResp;
                end
            end
            TxResp: begin
                check_eq("bready", axi.bready, 1);
                check_eq("wvalid_in_b", axi.wvalid, 0);
                if (axi.bvalid) begin
                    exp_done = onehot(g);
                    exp_err  = (axi.bresp != 2'b00) ? onehot(g) : 2'b00;
                    complete(axi.bresp != 2'b00);
                    ph = TxNone;
                end
            end
            TxReject: begin
                check_eq("awvalid_rej", axi.awvalid, 0);
                exp_done = onehot(g);
                exp_err  = onehot(g);
                complete(1);
                ph = TxNone;
            end
            default: begin
                check_eq("idle_bus", {axi.awvalid, axi.wvalid, axi.bready}, 0);
            end
        endcase
        if (cur != TxData) check_eq("wready_idle", req_wready, 0);
        check_eq("req_done", req_done, exp_done);
        check_eq("req_err", req_err, exp_err);
        if (cur == TxNone && pend != 2'b00) begin
            if (pend == 2'b11) eg = 1 - last_served;
            else               eg = pend[1] ? 1 : 0;
            check_eq("req_ready", req_ready, onehot(eg));
            g       = eg;
            c_addr  = p_addr[eg];
            c_len   = p_len[eg];
            pend[eg] = 1'b0;
            beats   = 0;
            aw_wait = 0;
            grant_log.push_back(eg);
            start   = c_addr[11:0] & 12'hFFC;
            ph      = (start + 4 * (c_len + 1) > 4096) ? TxReject : TxAddr;
        end else begin
            check_eq("req_ready_quiet", req_ready, 0);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((pend != 2'b00 || ph != TxNone) && n < budget) begin
            cycle();
            n++;
        end
        check_eq("drain", {pend, 1'(ph != TxNone)}, 0);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_aw", {axi.awvalid, axi.awaddr, axi.awlen, axi.awid}, 0);
        check_eq("rst_w", {axi.wvalid, axi.wlast, axi.bready}, 0);
        check_eq("rst_req", {req_ready, req_wready, req_done, req_err}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        pend       = '0;
        req_valid  = '0;
        req_wvalid = '0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst         = 1'b0;
        ph          = TxNone;
        last_served = 1;
        for (int i = 0; i < 2; i++) begin
            tx_seq[i] = 0;
            rx_seq[i] = 0;
        end
    endtask

    initial begin
        int n;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        axi.bid     = 1'b0;
        for (int i = 0; i < 2; i++) begin
            p_addr[i] = '0;
            p_len[i]  = '0;
            tx_seq[i] = 0;
            rx_seq[i] = 0;
        end
        do_reset();

        // Single requester, unaligned address, slave always ready
        post(0, 13'h003, 8'd7);
        wait_idle(200);
        check_eq("t1_beats", last_beats, 8);
        check_eq("t1_err", last_err, 0);
        check_eq("t1_grant", last_g, 0);

        // Simultaneous requests after reset, twice
        do_reset();
        for (int r = 0; r < 2; r++) begin
            grant_log.delete();
            post(0, 13'h100, 8'd3);
            post(1, 13'h200, 8'd3);
            wait_idle(200);
            check_eq("t2_count", grant_log.size(), 2);
            if (grant_log.size() == 2) begin
                check_eq("t2_first", grant_log[0], 0);
                check_eq("t2_second", grant_log[1], 1);
            end
        end

        // Slow AW and toggling wready
        aw_hold  = 5;
        w_toggle = 1;
        post(0, 13'h080, 8'd3);
        wait_idle(200);
        check_eq("t3_beats", last_beats, 4);
        aw_hold  = 0;
        w_toggle = 0;

        // 4 KiB crossing is rejected without AXI traffic
        post(1, 13'h0FF0, 8'd7);
        wait_idle(50);
        check_eq("t4_err", last_err, 1);
        check_eq("t4_beats", last_beats, 0);
        check_eq("t4_grant", last_g, 1);

        // Slave error, then a clean burst
        force_bresp = 2'b10;
        post(0, 13'h010, 8'd1);
        wait_idle(100);
        check_eq("t5_err", last_err, 1);
        force_bresp = 2'b00;
        post(1, 13'h020, 8'd2);
        wait_idle(100);
        check_eq("t5_next_err", last_err, 0);
        check_eq("t5_next_beats", last_beats, 3);

        // Boundaries: single beat, full 256 beats, burst ending exactly at the page edge
        post(0, 13'h100, 8'd0);
        wait_idle(100);
        check_eq("len0_beats", last_beats, 1);
        post(0, 13'h000, 8'd255);
        wait_idle(600);
        check_eq("len255_beats", last_beats, 256);
        post(1, 13'h0FE0, 8'd7);
        wait_idle(100);
        check_eq("edge_err", last_err, 0);
        check_eq("edge_beats", last_beats, 8);

        // Asynchronous reset mid-burst
        post(0, 13'h040, 8'd7);
        n = 0;
        while (!(ph == TxData && beats == 3) && n < 100) begin
            cycle();
            n++;
        end
        check_eq("t6_reached", beats, 3);
        #2;
        check_eq("t6_pre_wvalid", axi.wvalid, 1);
        rst = 1'b1;
        #1;
        check_eq("t6_rst_bus", {axi.wvalid, axi.awvalid, axi.bready}, 0);
        check_eq("t6_rst_req", {req_wready, req_done}, 0);
        do_reset();
        post(1, 13'h300, 8'd5);
        wait_idle(200);
        check_eq("t6_after_err", last_err, 0);
        check_eq("t6_after_beats", last_beats, 6);

        // Randomized traffic
        use_force = 0;
        for (int k = 0; k < 60; k++) begin
            p_aw = $urandom_range(100, 30);
            p_w  = $urandom_range(100, 30);
            p_b  = $urandom_range(100, 30);
            p_wv = $urandom_range(100, 40);
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && chance(60)) begin
                    post(i, AW'($urandom_range(8191, 0)),
                         chance(5) ? 8'd255 : 8'($urandom_range(15, 0)));
                end
            end
            repeat ($urandom_range(20, 1)) cycle();
        end
        wait_idle(3000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
